// File: rtl/timeout_scheduler_if.sv
// Bundle between the game-control requesters / shared prescaler and the timeout scheduler.
// The master side drives requests and ticks; the slave side (the scheduler) owns the grants and timer controls.
interface timeout_scheduler_if #(
   parameter int NREQ  = 2,
   parameter int DUR_W = 8
);
   logic [NREQ-1:0]       req;
   logic [NREQ*DUR_W-1:0] req_dur;
   logic                  tick_100ms;
   logic                  tmr_enable;
   logic                  tmr_clear;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic                  busy;

   modport master (
      output req, req_dur, tick_100ms,
      input  tmr_enable, tmr_clear, gnt, done, busy
   );

   modport slave (
      input  req, req_dur, tick_100ms,
      output tmr_enable, tmr_clear, gnt, done, busy
   );
endinterface

// File: rtl/timeout_scheduler.sv
// Round-robin owner of one shared 100 ms prescaler chain: grants it, clears it, counts ticks
// for the owner's duration, then pulses done to that owner.
module timeout_scheduler #(
   parameter int NREQ  = 2,
   parameter int DUR_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   timeout_scheduler_if.slave bus
);
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t             state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   owner;
   logic [DUR_W-1:0]   count;
   logic [PTR_W-1:0]   pick_idx;
   logic [PTR_W-1:0]   cand;
   logic               pick_any;
   logic [NREQ-1:0]    pick_oh;
   logic [DUR_W-1:0]   dur_arr [NREQ];

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (int'(p) >= NREQ - 1) return '0;
      return p + PTR_W'(1);
   endfunction

   always_comb begin
      for (int i = 0; i < NREQ; i++) dur_arr[i] = bus.req_dur[i*DUR_W +: DUR_W];
   end

   // Search downward so the candidate closest to rr_ptr is written last and wins.
   always_comb begin
      pick_any = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = PTR_W'((int'(rr_ptr) + i) % NREQ);
         if (bus.req[cand]) begin
            pick_any = 1'b1;
            pick_idx = cand;
         end
      end
      pick_oh = NREQ'(1) << pick_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         owner          <= '0;
         count          <= '0;
         bus.gnt        <= '0;
         bus.done       <= '0;
         bus.tmr_enable <= 1'b0;
         bus.tmr_clear  <= 1'b0;
         bus.busy       <= 1'b0;
      end else begin
         bus.done      <= '0;
         bus.tmr_clear <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  owner         <= pick_idx;
                  count         <= dur_arr[pick_idx];
                  bus.gnt       <= pick_oh;
                  bus.tmr_clear <= 1'b1;
                  bus.busy      <= 1'b1;
                  state         <= LOAD;
               end
            end
            LOAD: begin
               if (!bus.req[owner]) begin
                  bus.gnt        <= '0;
                  bus.busy       <= 1'b0;
                  bus.tmr_enable <= 1'b0;
                  count          <= '0;
                  rr_ptr         <= next_ptr(owner);
                  state          <= IDLE;
               end else if (count == '0) begin
                  bus.done <= bus.gnt;
                  state    <= DONE;
               end else begin
                  bus.tmr_enable <= 1'b1;
                  state          <= RUN;
               end
            end
            RUN: begin
               // A dropped request beats a coincident final tick.
               if (!bus.req[owner]) begin
                  bus.gnt        <= '0;
                  bus.busy       <= 1'b0;
                  bus.tmr_enable <= 1'b0;
                  count          <= '0;
                  rr_ptr         <= next_ptr(owner);
                  state          <= IDLE;
               end else if (bus.tick_100ms) begin
                  count <= count - DUR_W'(1);
                  if (count == DUR_W'(1)) begin
                     bus.done       <= bus.gnt;
                     bus.tmr_enable <= 1'b0;
                     state          <= DONE;
                  end
               end
            end
            DONE: begin
               bus.gnt  <= '0;
               bus.busy <= 1'b0;
               rr_ptr   <= next_ptr(owner);
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
